// File: rtl/perceptron_driver.sv
// rtl/perceptron_driver.sv - host-side sequencer feeding config and samples into the perceptron core
// Optional weight readback after each sample is enabled by defining PERCEPTRON_READBACK_EN.
module perceptron_driver #(
  parameter int TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cfg_valid,
  input  logic [5:0] i_cfg_w0,
  input  logic [5:0] i_cfg_w1,
  input  logic [5:0] i_cfg_w2,
  input  logic [5:0] i_cfg_n,
  output logic       o_cfg_done,
  input  logic       i_s_valid,
  output logic       o_s_ready,
  input  logic [5:0] i_s_x1,
  input  logic [5:0] i_s_x2,
  input  logic       i_s_update,
  input  logic       i_s_label,
  output logic       o_r_valid,
  input  logic       i_r_ready,
  output logic       o_r_class,
  output logic       o_r_timeout,
  output logic [5:0] o_r_w0,
  output logic [5:0] o_r_w1,
  output logic [5:0] o_r_w2,
  output logic       o_p_go,
  output logic       o_p_update,
  output logic       o_p_correct,
  output logic [1:0] o_p_sel_out,
  output logic [5:0] o_p_in_val,
  input  logic       i_p_sync,
  input  logic       i_p_done,
  input  logic       i_p_classification,
  input  logic [5:0] i_p_out_val
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, LD_W0, LD_W1, LD_W2, LD_N, READY, TX_X1, TX_X2, WAIT,
`ifdef PERCEPTRON_READBACK_EN
    RB_W0, RB_W1, RB_W2,
`endif
    RESP, DEAD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [5:0]    r_cfg_w0, r_cfg_w1, r_cfg_w2, r_cfg_n;
  logic [5:0]    r_x1, r_x2;
  logic          r_upd, r_lbl;
  logic [TW-1:0] r_timer;
  logic          r_cfg_done;
  logic          r_class;
  logic          r_timeout;

  logic          w_go, w_upd, w_corr, w_s_ready, w_r_valid;
  logic [1:0]    w_sel;
  logic [5:0]    w_in_val;

  always_comb begin
    w_next    = r_state;
    w_go      = 1'b0;
    w_upd     = 1'b0;
    w_corr    = 1'b0;
    w_sel     = 2'd0;
    w_in_val  = 6'd0;
    w_s_ready = 1'b0;
    w_r_valid = 1'b0;
    case (r_state)
      IDLE: if (i_cfg_valid) w_next = LD_W0;
      LD_W0: begin
        w_go = 1'b1;
        w_in_val = r_cfg_w0;
        if (i_p_sync) w_next = LD_W1;
      end
      LD_W1: begin
        w_go = 1'b1;
        w_in_val = r_cfg_w1;
        if (i_p_sync) w_next = LD_W2;
      end
      LD_W2: begin
        w_go = 1'b1;
        w_in_val = r_cfg_w2;
        if (i_p_sync) w_next = LD_N;
      end
      LD_N: begin
        w_go = 1'b1;
        w_in_val = r_cfg_n;
        if (i_p_sync) w_next = READY;
      end
      READY: begin
        w_s_ready = 1'b1;
        if (i_s_valid) w_next = TX_X1;
      end
      TX_X1: begin
        w_go = 1'b1;
        w_in_val = r_x1;
        w_upd = r_upd;
        w_corr = r_lbl;
        if (i_p_sync) w_next = TX_X2;
      end
      // The core never syncs x2, so this word is sent for exactly one cycle.
      TX_X2: begin
        w_go = 1'b1;
        w_in_val = r_x2;
        w_upd = r_upd;
        w_corr = r_lbl;
        w_next = WAIT;
      end
      WAIT: begin
        w_upd = r_upd;
        w_corr = r_lbl;
        if (i_p_done) begin
`ifdef PERCEPTRON_READBACK_EN
          w_next = RB_W0;
`else
          w_next = RESP;
`endif
        end else if (r_timer == '0) begin
          w_next = RESP;
        end
      end
`ifdef PERCEPTRON_READBACK_EN
      RB_W0: begin
        w_sel = 2'd3;
        w_next = RB_W1;
      end
      RB_W1: begin
        w_sel = 2'd2;
        w_next = RB_W2;
      end
      RB_W2: begin
        w_sel = 2'd1;
        w_next = RESP;
      end
`endif
      // After a timeout the core state is unknown, so the driver parks until reset.
      RESP: begin
        w_r_valid = 1'b1;
        if (i_r_ready) w_next = r_timeout ? DEAD : READY;
      end
      DEAD: w_next = DEAD;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_cfg_w0   <= '0;
      r_cfg_w1   <= '0;
      r_cfg_w2   <= '0;
      r_cfg_n    <= '0;
      r_x1       <= '0;
      r_x2       <= '0;
      r_upd      <= 1'b0;
      r_lbl      <= 1'b0;
      r_timer    <= '0;
      r_cfg_done <= 1'b0;
      r_class    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_cfg_valid) begin
        r_cfg_w0 <= i_cfg_w0;
        r_cfg_w1 <= i_cfg_w1;
        r_cfg_w2 <= i_cfg_w2;
        r_cfg_n  <= i_cfg_n;
      end
      if (r_state == LD_N && i_p_sync) r_cfg_done <= 1'b1;
      if (r_state == READY && i_s_valid) begin
        r_x1  <= i_s_x1;
        r_x2  <= i_s_x2;
        r_upd <= i_s_update;
        r_lbl <= i_s_label;
      end
      if (r_state == TX_X2) begin
        r_timer <= TMO_LOAD;
      end else if (r_state == WAIT && r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end
      if (r_state == WAIT) begin
        if (i_p_done) r_class <= i_p_classification;
        else if (r_timer == '0) r_timeout <= 1'b1;
      end
    end
  end

`ifdef PERCEPTRON_READBACK_EN
  logic [5:0] r_w0, r_w1, r_w2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_w0 <= '0;
      r_w1 <= '0;
      r_w2 <= '0;
    end else begin
      if (r_state == RB_W0) r_w0 <= i_p_out_val;
      if (r_state == RB_W1) r_w1 <= i_p_out_val;
      if (r_state == RB_W2) r_w2 <= i_p_out_val;
    end
  end

  assign o_r_w0 = r_w0;
  assign o_r_w1 = r_w1;
  assign o_r_w2 = r_w2;
`else
  logic w_unused_out_val;
  assign w_unused_out_val = ^i_p_out_val;
  assign o_r_w0 = 6'd0;
  assign o_r_w1 = 6'd0;
  assign o_r_w2 = 6'd0;
`endif

  assign o_cfg_done  = r_cfg_done;
  assign o_s_ready   = w_s_ready;
  assign o_r_valid   = w_r_valid;
  assign o_r_class   = r_class;
  assign o_r_timeout = r_timeout;
  assign o_p_go      = w_go;
  assign o_p_update  = w_upd;
  assign o_p_correct = w_corr;
  assign o_p_sel_out = w_sel;
  assign o_p_in_val  = w_in_val;

endmodule

// File: doc/perceptron_driver.md
# perceptron_driver

Host-side sequencer for the `perceptron` core. It loads the initial weights and learning rate once after reset, then streams (x1, x2, label) samples into the core over the core's go/sync word protocol. For each sample it waits for `done` and returns the classification, plus optional weight readback, on a valid/ready result port. It sits between the chip I/O or test harness and the core, and owns every core input except clock and reset.

## Interface
Parameters:
- `TIMEOUT`, default 16: cycles allowed from the x2 send to core `done` before the driver aborts the sample.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high. The core must be reset in the same cycle (`reset_l = ~reset` at the top level).
- `cfg_valid` in 1: one-cycle pulse; captures `cfg_w0`/`cfg_w1`/`cfg_w2`/`cfg_n`.
- `cfg_w0`, `cfg_w1`, `cfg_w2`, `cfg_n` in 6 each: initial weights and learning rate, fixed-point 3.3.
- `cfg_done` out 1: high once configuration has been fully accepted; stays high until reset.
- `s_valid` in 1, `s_ready` out 1: sample handshake.
- `s_x1`, `s_x2` in 6: sample features.
- `s_update` in 1: train on this sample.
- `s_label` in 1: expected class.
- `r_valid` out 1, `r_ready` in 1: result handshake.
- `r_class` out 1: core classification.
- `r_timeout` out 1: sample aborted.
- `r_w0`, `r_w1`, `r_w2` out 6: post-sample weights. Driven only when `PERCEPTRON_READBACK_EN` is defined; otherwise tied to 0.
- `p_go`, `p_update`, `p_correct` out 1; `p_sel_out` out 2; `p_in_val` out 6: drive the core.
- `p_sync`, `p_done`, `p_classification` in 1; `p_out_val` in 6: from the core.

## Operation
- States: `IDLE`, `LD_W0`, `LD_W1`, `LD_W2`, `LD_N`, `READY`, `TX_X1`, `TX_X2`, `WAIT`, `RB_W0`, `RB_W1`, `RB_W2`, `RESP`, `DEAD`.
- `IDLE`: ignores samples. `cfg_valid` registers the four config words and moves to `LD_W0`. A `cfg_valid` outside `IDLE` is ignored, because the core only reconfigures from reset.
- `LD_*`: drive `p_go=1` and `p_in_val` = the corresponding word. Advance only on a cycle with `p_sync=1`. After `LD_N` is accepted, set `cfg_done=1` and go to `READY`.
- `READY`: `s_ready=1`. On `s_valid & s_ready`, register the sample and go to `TX_X1`.
- `TX_X1`: `p_go=1`, `p_in_val=x1`. Advance on `p_sync`.
- `TX_X2`: `p_go=1`, `p_in_val=x2` for exactly one cycle. The core gives no sync for x2, so acceptance is unconditional. Go to `WAIT` and load the timeout counter with `TIMEOUT-1`.
- `p_update` and `p_correct` are held at the registered `s_update`/`s_label` from `TX_X1` through `WAIT`. Both are 0 in every other state.
- `WAIT`: on `p_done`, capture `p_classification` into `r_class` and go to `RB_W0` (macro defined) or `RESP`. When the counter reaches 0 without `p_done`, set `r_timeout=1` and go to `RESP`. The sticky `DEAD` state follows that `RESP`, since the core's state is then unknown; only reset leaves `DEAD`.
- `RB_Wk`: `p_sel_out` = 3/2/1 for w0/w1/w2, with `p_go=0`. Register `p_out_val` into `r_wk` at the end of the cycle.
- `RESP`: `r_valid=1`; hold all `r_*` stable until `r_ready`, then return to `READY`.
- `p_sel_out` defaults to 0 (core sum) outside `RB_*`.
- Reset values: state `IDLE`; every output 0, including `cfg_done`, `s_ready`, `r_valid`, `r_*` and `p_*`.
- Reset mid-operation: both blocks return to the start in the same cycle; any in-flight sample is dropped without a response.

## Timing
- Config: 4 cycles minimum from the cycle after `cfg_valid` (one word per cycle while the core returns sync combinationally). `cfg_done` rises the cycle after the `LD_N` sync.
- Sample, no update: accept at cycle t; `TX_X1` t+1, `TX_X2` t+2, core `done` t+4 (`WAIT` entered t+3). `RESP` at t+5 without readback, t+8 with readback.
- Sample with update: `done` arrives 1, 4, 7 or 10 cycles after the core's compute cycle, depending on the number of weight updates (0–3). The worst case of 11 cycles after x2 fits within `TIMEOUT=16`.
- `s_ready` is combinational from the state only. There is no combinational path from `s_valid` to `s_ready` or from `r_ready` to `r_valid`.
- Back-to-back: with `r_ready` held high, the next sample is accepted the cycle after `RESP`.

## Configuration
- `PERCEPTRON_READBACK_EN` defined: after each `done`, the three `RB_*` cycles execute and `r_w0..r_w2` carry the core's weights as sampled after the update.
- Not defined: no `RB_*` states; `WAIT` goes directly to `RESP`; `r_w*` are constant 0 and `p_sel_out` is constant 0.

## Test plan
- Config: `cfg_valid` with w0=0x08, w1=0x10, w2=0x00, n=0x04 -> `p_in_val` sequence 08,10,00,04 on consecutive `p_go` cycles; `cfg_done` rises 5 cycles after the pulse.
- No-update sample: x1=0x08, x2=0x08, update=0 -> `done` at t+4; `r_class=1`; `r_valid` at t+5 (macro off).
- Training, misclassified: w=(0x08,0,0), label=0, update=1 -> three weight updates; with readback, `r_w*` differ from the configured weights; `r_valid` before the timeout.
- Backpressure: `r_ready=0` for 10 cycles -> `r_*` stable, `s_ready=0`; the next sample is accepted one cycle after `r_ready` rises.
- Timeout: core model never asserts `done` -> `r_timeout=1` at `TX_X2`+17; afterwards `s_ready` stays 0 until reset.
- Reset during `WAIT` -> all outputs 0 next cycle; `cfg_valid` then reconfigures normally.
